shift_auto_scale: RTL
=====================

# shift_auto_scale

Streaming auto-scaler that picks the shift amount for the downstream `bit_shift`-style left shifter. It measures the peak absolute magnitude of signed samples over fixed windows of 2^WINDOW_LOG2 valid samples. At each window end it outputs a left-shift count that restores the dynamic range while keeping TARGET_HEADROOM spare sign bits. It sits directly upstream of the shifter in the gain/requantisation path.

## Interface
- DATA_WIDTH, 8, sample width (two's complement); ≥ 2.
- WINDOW_LOG2, 4, window length = 2^WINDOW_LOG2 valid samples; ≥ 1.
- SHIFT_WIDTH, 3, width of shift_amt; must hold DATA_WIDTH-1.
- TARGET_HEADROOM, 1, redundant sign bits left unused after shifting.
- MAX_SHIFT, 7, upper clamp on shift_amt; ≤ DATA_WIDTH-1.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- data_in  in  DATA_WIDTH  signed sample.
- data_valid  in  1  data_in qualifier; sampled every edge.
- shift_amt  out  SHIFT_WIDTH  current left-shift count; holds between updates.
- shift_valid  out  1  one-cycle pulse when shift_amt/peak_out update.
- peak_out  out  DATA_WIDTH  peak |sample| of the last completed window (unsigned, MSB always 0).

## Operation
- Stage 1: on data_valid, register abs(data_in) and a valid bit. abs(-2^(DATA_WIDTH-1)) saturates to 2^(DATA_WIDTH-1)-1.
- Stage 2:
  - Running peak = max(running peak, stage-1 abs) on each stage-1 valid.
  - Window counter (WINDOW_LOG2 bits) increments per stage-1 valid and wraps at 2^WINDOW_LOG2.
  - On the last sample of a window: latch max(running peak, that abs) into peak_hold, raise an internal done flag, and load running peak with 0.
  - The next sample, even if valid in the immediately following cycle, starts the new window. No sample is lost or double-counted.
- Stage 3: on done, compute headroom H = (leading zeros of peak_hold in DATA_WIDTH bits) − 1, range 0..DATA_WIDTH-1. peak_hold = 0 gives H = DATA_WIDTH-1.
- Stage 4:
  - shift_amt = min(MAX_SHIFT, max(0, H − TARGET_HEADROOM)).
  - peak_out = peak_hold.
  - shift_valid = 1 for exactly one cycle.
- Gaps in data_valid stall window counting only. Pipeline valid bits still advance every cycle.
- No backpressure. The downstream stage must accept shift_amt on the pulse.
- Reset:
  - Clears all pipeline valids, the counter, running peak and peak_hold.
  - Outputs: shift_amt=0, shift_valid=0, peak_out=0.
  - Reset mid-window discards the partial window.
  - Results in flight at reset are dropped; no pulse appears after reset for data sampled before it.
  - rst has priority over data_valid in the same cycle, and that sample is discarded.

## Timing
- Last sample of a window presented with data_valid in cycle N → shift_valid high in cycle N+4, with shift_amt and peak_out updated in that same cycle.
- Outputs are fully registered; no combinational path from inputs to outputs.
- Throughput: one sample per cycle sustained. Consecutive windows produce pulses exactly 2^WINDOW_LOG2 cycles apart.
- Minimum window length of 2 samples guarantees pulses never collide.
- Reset asserted in cycle R → all outputs at reset values from cycle R+1.

## Test plan
Defaults: DATA_WIDTH=8, WINDOW_LOG2=2, TARGET_HEADROOM=1, MAX_SHIFT=7.
- Basic window:
  - Stimulus: valid samples 3, −5, 2, 1 in cycles 0–3.
  - Response: shift_valid only in cycle 7; peak_out=5; shift_amt=3 (H=4).
- All-zero window:
  - Stimulus: four valid 0s.
  - Response: peak_out=0; shift_amt=6. Re-run with MAX_SHIFT=2 → shift_amt=2.
- Most-negative value:
  - Stimulus: window −128, 0, 0, 0.
  - Response: peak_out=127; shift_amt=0, i.e. no negative underflow from H−TARGET_HEADROOM.
- Valid gaps:
  - Stimulus: four valid samples of 16 in cycles 0, 2, 5, 8.
  - Response: single pulse in cycle 12; peak_out=16; shift_amt=1. No pulse earlier.
- Back-to-back windows:
  - Stimulus: eight consecutive valid samples: 64, 1, 1, 1 then 1, 1, 1, 1.
  - Response: pulses in cycles 7 and 11.
    - Cycle 7: shift_amt=0, peak_out=64.
    - Cycle 11: shift_amt=5, peak_out=1.
  - shift_amt holds 0 in cycles 8–10.
- Reset mid-window:
  - Stimulus: two samples of 100, rst for one cycle, then four samples of 1.
  - Response: no pulse for the aborted window; one pulse with peak_out=1, shift_amt=5. Outputs are 0 in the cycle after rst.

Source files
------------

// File: rtl/shift_auto_scale.sv
// Windowed peak detector that selects the left-shift count for the downstream shifter.
// Four registered stages: abs, window peak, headroom count, clamped shift output.
module shift_auto_scale #(
    parameter int DATA_WIDTH      = 8,
    parameter int WINDOW_LOG2     = 4,
    parameter int SHIFT_WIDTH     = 3,
    parameter int TARGET_HEADROOM = 1,
    parameter int MAX_SHIFT       = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  data_in,
    input  logic                   data_valid,
    output logic [SHIFT_WIDTH-1:0] shift_amt,
    output logic                   shift_valid,
    output logic [DATA_WIDTH-1:0]  peak_out
);

    localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] MOST_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};

    logic [DATA_WIDTH-1:0]  abs_val;
    logic [DATA_WIDTH-1:0]  s1_abs;
    logic                   s1_valid;
    logic [WINDOW_LOG2-1:0] win_cnt;
    logic [DATA_WIDTH-1:0]  run_peak;
    logic [DATA_WIDTH-1:0]  win_peak;
    logic [DATA_WIDTH-1:0]  peak_hold;
    logic                   done;
    logic [SHIFT_WIDTH-1:0] h_q;
    logic [DATA_WIDTH-1:0]  s3_peak;
    logic                   s3_valid;
    logic [SHIFT_WIDTH-1:0] shift_next;
    int                     shift_raw;

    function automatic int unsigned lead_zeros(input logic [DATA_WIDTH-1:0] v);
        int unsigned n;
        n = DATA_WIDTH;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            if (v[i]) n = DATA_WIDTH - 1 - i;
        end
        return n;
    endfunction

    // The most negative sample has no positive twin, so it saturates.
    always_comb begin
        abs_val = data_in;
        if (data_in[DATA_WIDTH-1]) begin
            if (data_in == MOST_NEG) abs_val = MOST_POS;
            else                     abs_val = -data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_abs   <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= data_valid;
            if (data_valid) s1_abs <= abs_val;
        end
    end

    always_comb begin
        win_peak = run_peak;
        if (s1_abs > run_peak) win_peak = s1_abs;
    end

    // The window's final sample is folded into peak_hold directly, letting the
    // next window start on the very next valid sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_cnt   <= '0;
            run_peak  <= '0;
            peak_hold <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (s1_valid) begin
                win_cnt <= win_cnt + 1'b1;
                if (win_cnt == '1) begin
                    peak_hold <= win_peak;
                    run_peak  <= '0;
                    done      <= 1'b1;
                end else begin
                    run_peak <= win_peak;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_q      <= '0;
            s3_peak  <= '0;
            s3_valid <= 1'b0;
        end else begin
            s3_valid <= done;
            if (done) begin
                h_q     <= SHIFT_WIDTH'(lead_zeros(peak_hold) - 1);
                s3_peak <= peak_hold;
            end
        end
    end

    always_comb begin
        shift_raw = int'(h_q) - TARGET_HEADROOM;
        if (shift_raw < 0)         shift_raw = 0;
        if (shift_raw > MAX_SHIFT) shift_raw = MAX_SHIFT;
        shift_next = SHIFT_WIDTH'(shift_raw);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_amt   <= '0;
            shift_valid <= 1'b0;
            peak_out    <= '0;
        end else begin
            shift_valid <= s3_valid;
            if (s3_valid) begin
                shift_amt <= shift_next;
                peak_out  <= s3_peak;
            end
        end
    end

endmodule
